// File: rtl/uart_mult_byte_tx_pkg.sv
// Shared definitions for the multi-byte UART packet transmitter:
// bit timing, CRC8 constants and helper, FSM state encoding.
package uart_mult_byte_tx_pkg;

    localparam logic [7:0] CRC8_POLY     = 8'h07;
    localparam logic [7:0] CRC8_INIT     = 8'h00;
    localparam logic [7:0] HEAD_BYTE_DEF = 8'h55;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_GAP   = 3'd4,
        S_NEXT  = 3'd5,
        S_DONE  = 3'd6
    } tx_state_e;

    function automatic int bit_cycles(input int clk_freq, input int bps);
        return clk_freq / bps;
    endfunction

    // One CRC8 byte step, MSB first, no reflection.
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            if (c[7]) begin
                c = {c[6:0], 1'b0} ^ CRC8_POLY;
            end else begin
                c = {c[6:0], 1'b0};
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/uart_mult_byte_tx_crc8.sv
// Combinational CRC8 update of one byte (poly 0x07).
module crc8_byte_update
    import uart_mult_byte_tx_pkg::*;
(
    input  logic [7:0] crc_in_i,
    input  logic [7:0] data_in_i,
    output logic [7:0] crc_out_o
);

    // Bytewise CRC update
    always_comb begin
        crc_out_o = crc8_step(crc_in_i, data_in_i);
    end

endmodule

// File: rtl/uart_mult_byte_tx.sv
// Frames a latched payload as HEAD + payload + CRC8 and shifts it out 8N1, LSB first.
module uart_mult_byte_tx
    import uart_mult_byte_tx_pkg::*;
#(
    parameter int         CLK_FREQ      = 50000000,
    parameter int         UART_BPS      = 115200,
    parameter int         PAYLOAD_BYTES = 11,
    parameter logic [7:0] HEAD_BYTE     = HEAD_BYTE_DEF,
    parameter int         GAP_BITS      = 0
) (
    input  logic                       clk_50M,
    input  logic                       rst,
    input  logic                       tx_start,
    input  logic [8*PAYLOAD_BYTES-1:0] tx_payload,
    output logic                       tx_busy,
    output logic                       tx_done,
    output logic                       uart_txd
);

    localparam int BIT_CYC = bit_cycles(CLK_FREQ, UART_BPS);
    localparam int BW      = $clog2(BIT_CYC);
    localparam int IW      = $clog2(PAYLOAD_BYTES + 2);
    localparam int PW      = 8 * PAYLOAD_BYTES;
    localparam bit HAS_GAP = (GAP_BITS > 0);

    localparam logic [BW-1:0] BAUD_LAST = BW'(BIT_CYC - 1);
    localparam logic [BW-1:0] BAUD_PRE  = BW'(BIT_CYC - 2);
    localparam logic [3:0]    GAP_LAST  = 4'(HAS_GAP ? GAP_BITS - 1 : 0);
    localparam logic [IW-1:0] IDX_CRC   = IW'(PAYLOAD_BYTES);
    localparam logic [IW-1:0] IDX_LAST  = IW'(PAYLOAD_BYTES + 1);

    tx_state_e       state_q, state_d;
    logic [BW-1:0]   baud_q, baud_d;
    logic [3:0]      bit_q, bit_d;
    logic [IW-1:0]   byte_q, byte_d;
    logic [PW-1:0]   shadow_q, shadow_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      crc_q, crc_d;
    logic [7:0]      crc_next_s;
    logic            txd_q, txd_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    crc8_byte_update u_crc (
        .crc_in_i  (crc_q),
        .data_in_i (shadow_q[7:0]),
        .crc_out_o (crc_next_s)
    );

    // State and datapath registers
    always_ff @(posedge clk_50M) begin
        if (rst) begin
            state_q  <= S_IDLE;
            baud_q   <= '0;
            bit_q    <= 4'd0;
            byte_q   <= '0;
            shadow_q <= '0;
            shift_q  <= 8'h00;
            crc_q    <= CRC8_INIT;
            txd_q    <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            byte_q   <= byte_d;
            shadow_q <= shadow_d;
            shift_q  <= shift_d;
            crc_q    <= crc_d;
            txd_q    <= txd_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Next-state logic; the NEXT cycle is the final stop/gap clock so each byte slot stays exact
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        byte_d   = byte_q;
        shadow_d = shadow_q;
        shift_d  = shift_q;
        crc_d    = crc_q;
        case (state_q)
            S_IDLE: begin
                if (tx_start) begin
                    state_d  = S_START;
                    shadow_d = tx_payload;
                    shift_d  = HEAD_BYTE;
                    byte_d   = '0;
                    crc_d    = CRC8_INIT;
                    baud_d   = '0;
                    bit_d    = 4'd0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                if (baud_q == BAUD_LAST) begin
                    state_d = S_DATA;
                    baud_d  = '0;
                    bit_d   = 4'd0;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            S_DATA: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d  = '0;
                    shift_d = {1'b1, shift_q[7:1]};
                    if (bit_q == 4'd7) begin
                        state_d = S_STOP;
                        bit_d   = 4'd0;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            S_STOP: begin
                if (!HAS_GAP && (baud_q == BAUD_PRE)) begin
                    state_d = S_NEXT;
                    baud_d  = '0;
                end else if (HAS_GAP && (baud_q == BAUD_LAST)) begin
                    state_d = S_GAP;
                    baud_d  = '0;
                    bit_d   = 4'd0;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            S_GAP: begin
                if ((bit_q == GAP_LAST) && (baud_q == BAUD_PRE)) begin
                    state_d = S_NEXT;
                    baud_d  = '0;
                    bit_d   = 4'd0;
                end else if (baud_q == BAUD_LAST) begin
                    baud_d = '0;
                    bit_d  = bit_q + 4'd1;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            S_NEXT: begin
                if (byte_q == IDX_LAST) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_START;
                    baud_d  = '0;
                    byte_d  = byte_q + IW'(1);
                    if (byte_q == IDX_CRC) begin
                        shift_d = crc_q;
                    end else begin
                        shift_d  = shadow_q[7:0];
                        shadow_d = shadow_q >> 8;
                        crc_d    = crc_next_s;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Registered outputs follow the next state so the line changes on the same edge as the FSM
    always_comb begin
        txd_d = 1'b1;
        case (state_d)
            S_START: txd_d = 1'b0;
            S_DATA:  txd_d = shift_d[0];
            default: txd_d = 1'b1;
        endcase
        busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d = (state_d == S_DONE);
    end

    assign uart_txd = txd_q;
    assign tx_busy  = busy_q;
    assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_mult_byte_tx.sv
// Self-checking bench for uart_mult_byte_tx: scoreboarded byte decoding plus cycle-exact line checks.
module tb_uart_mult_byte_tx;

    localparam int CLKF = 1000000;
    localparam int BPS  = 100000;
    localparam int BC   = 10;

    typedef struct {
        logic [71:0] payload;
        logic [7:0]  crc;
        int          frame_clk;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_a, start_b, start_c;
    logic [71:0] pay_a;
    logic [7:0]  pay_b, pay_c;
    logic        busy_a, busy_b, busy_c;
    logic        done_a, done_b, done_c;
    logic        txd_a, txd_b, txd_c;
    int          sel;
    logic        txd_s, busy_s, done_s;
    int          cyc = 0;
    int          done_cnt [3] = '{0, 0, 0};
    logic [7:0]  exp_q [$];
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    uart_mult_byte_tx #(.CLK_FREQ(CLKF), .UART_BPS(BPS), .PAYLOAD_BYTES(9), .GAP_BITS(0)) dut_a (
        .clk_50M(clk), .rst(rst), .tx_start(start_a), .tx_payload(pay_a),
        .tx_busy(busy_a), .tx_done(done_a), .uart_txd(txd_a));
    uart_mult_byte_tx #(.CLK_FREQ(CLKF), .UART_BPS(BPS), .PAYLOAD_BYTES(1), .GAP_BITS(0)) dut_b (
        .clk_50M(clk), .rst(rst), .tx_start(start_b), .tx_payload(pay_b),
        .tx_busy(busy_b), .tx_done(done_b), .uart_txd(txd_b));
    uart_mult_byte_tx #(.CLK_FREQ(CLKF), .UART_BPS(BPS), .PAYLOAD_BYTES(1), .GAP_BITS(2)) dut_c (
        .clk_50M(clk), .rst(rst), .tx_start(start_c), .tx_payload(pay_c),
        .tx_busy(busy_c), .tx_done(done_c), .uart_txd(txd_c));

    assign txd_s  = (sel == 0) ? txd_a  : (sel == 1) ? txd_b  : txd_c;
    assign busy_s = (sel == 0) ? busy_a : (sel == 1) ? busy_b : busy_c;
    assign done_s = (sel == 0) ? done_a : (sel == 1) ? done_b : done_c;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (done_a === 1'b1) done_cnt[0] <= done_cnt[0] + 1;
        if (done_b === 1'b1) done_cnt[1] <= done_cnt[1] + 1;
        if (done_c === 1'b1) done_cnt[2] <= done_cnt[2] + 1;
    end

    function automatic logic [7:0] crc8_ref(input logic [71:0] p, input int n);
        logic [7:0] c;
        c = 8'h00;
        for (int k = 0; k < n; k++) begin
            c = c ^ p[8*k +: 8];
            for (int b = 0; b < 8; b++) begin
                c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
            end
        end
        return c;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic push_packet(input logic [71:0] p, input int n, input logic [7:0] crc);
        exp_q.push_back(8'h55);
        for (int k = 0; k < n; k++) exp_q.push_back(p[8*k +: 8]);
        exp_q.push_back(crc);
    endtask

    task automatic pulse(input int which);
        case (which)
            0: start_a = 1'b1;
            1: start_b = 1'b1;
            default: start_c = 1'b1;
        endcase
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        start_c = 1'b0;
    endtask

    task automatic recv_byte(output logic [7:0] b, output bit ok);
        int  n = 0;
        bit  mid_start;
        b  = 8'h00;
        ok = 1'b0;
        while (txd_s !== 1'b0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (txd_s !== 1'b0) return;
        repeat (BC / 2) @(negedge clk);
        mid_start = (txd_s === 1'b0);
        for (int i = 0; i < 8; i++) begin
            repeat (BC) @(negedge clk);
            b[i] = txd_s;
        end
        repeat (BC) @(negedge clk);
        ok = mid_start && (txd_s === 1'b1);
    endtask

    task automatic recv_packet(input int n, input string tag);
        logic [7:0] b, e;
        bit         ok;
        for (int k = 0; k < n; k++) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            recv_byte(b, ok);
            check($sformatf("%s_frame%0d", tag, k), {31'd0, ok}, 32'd1);
            check($sformatf("%s_byte%0d", tag, k), {24'd0, b}, {24'd0, e});
        end
    endtask

    task automatic wait_done(output int at, output bit ok);
        int n = 0;
        while (done_s !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        ok = (done_s === 1'b1);
        at = cyc;
    endtask

    // Cycle-exact comparison of the line from the current (first frame) cycle through tx_done.
    task automatic stream_check(input int nbytes, input int gap, input string tag);
        logic [7:0] bytes [4];
        int         total, slot, bi, pos, errs;
        logic       expb;
        for (int k = 0; k < nbytes; k++) bytes[k] = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        total = nbytes * (10 + gap) * BC;
        errs  = 0;
        for (int j = 0; j < total; j++) begin
            slot = j / BC;
            bi   = slot / (10 + gap);
            pos  = slot % (10 + gap);
            if (pos == 0)      expb = 1'b0;
            else if (pos <= 8) expb = bytes[bi][pos-1];
            else               expb = 1'b1;
            if (txd_s !== expb || busy_s !== 1'b1 || done_s !== 1'b0) begin
                if (errs < 4) $display("FAIL %s_line cycle=%0d actual=%b expected=%b", tag, j, txd_s, expb);
                errs++;
            end
            if (j < total - 1) @(negedge clk);
        end
        check({tag, "_line_errs"}, errs, 32'd0);
        @(negedge clk);
        check({tag, "_done"}, {31'd0, done_s}, 32'd1);
        check({tag, "_busy_at_done"}, {31'd0, busy_s}, 32'd0);
        check({tag, "_txd_at_done"}, {31'd0, txd_s}, 32'd1);
    endtask

    initial begin
        vec_t        vt [4];
        int          t_low, t_done, dc0, lows;
        bit          ok;
        logic [71:0] p9;

        vt[0] = '{72'h39_38_37_36_35_34_33_32_31, 8'hF4, 1100};
        vt[1] = '{72'h0, 8'h00, 1100};
        vt[2] = '{72'hFF_FF_FF_FF_FF_FF_FF_FF_FF, crc8_ref(72'hFF_FF_FF_FF_FF_FF_FF_FF_FF, 9), 1100};
        vt[3] = '{72'h80_01_7E_C3_5A_A5_10_08_01, crc8_ref(72'h80_01_7E_C3_5A_A5_10_08_01, 9), 1100};

        sel = 0; rst = 1'b1;
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        pay_a = 72'h0; pay_b = 8'h00; pay_c = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_txd_a", {31'd0, txd_a}, 32'd1);
        check("reset_busy_a", {31'd0, busy_a}, 32'd0);
        check("reset_done_a", {31'd0, done_a}, 32'd0);
        check("reset_txd_c", {31'd0, txd_c}, 32'd1);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Table: N=9 packets, decoded through the scoreboard, plus frame length.
        for (int i = 0; i < 4; i++) begin
            pay_a = vt[i].payload;
            push_packet(vt[i].payload, 9, vt[i].crc);
            pulse(0);
            t_low = cyc;
            check($sformatf("v%0d_start_low", i), {31'd0, txd_s}, 32'd0);
            check($sformatf("v%0d_busy", i), {31'd0, busy_s}, 32'd1);
            recv_packet(11, $sformatf("v%0d", i));
            wait_done(t_done, ok);
            check($sformatf("v%0d_done_seen", i), {31'd0, ok}, 32'd1);
            check($sformatf("v%0d_frame_len", i), t_done - t_low, vt[i].frame_clk);
            repeat (3) @(negedge clk);
        end

        // Second start during the packet is ignored.
        p9 = 72'h11_22_33_44_55_66_77_88_99;
        pay_a = p9;
        push_packet(p9, 9, crc8_ref(p9, 9));
        dc0 = done_cnt[0];
        pulse(0);
        fork
            recv_packet(11, "busy_start");
            begin
                repeat (36) @(negedge clk);
                pay_a = 72'hDE_AD_BE_EF_00_11_22_33_44;
                start_a = 1'b1;
                @(negedge clk);
                start_a = 1'b0;
            end
        join
        wait_done(t_done, ok);
        check("busy_start_done", {31'd0, ok}, 32'd1);
        lows = 0;
        repeat (150) begin
            @(negedge clk);
            if (txd_s !== 1'b1) lows++;
        end
        check("busy_start_quiet", lows, 32'd0);
        check("busy_start_one_done", done_cnt[0] - dc0, 32'd1);
        check("busy_start_sb_empty", exp_q.size(), 32'd0);

        // Reset during payload byte 2, data bit 4.
        pay_a = vt[3].payload;
        dc0 = done_cnt[0];
        pulse(0);
        repeat (355) @(negedge clk);
        check("midrst_in_packet", {31'd0, busy_s}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_txd", {31'd0, txd_s}, 32'd1);
        check("midrst_busy", {31'd0, busy_s}, 32'd0);
        lows = 0;
        repeat (300) begin
            @(negedge clk);
            if (txd_s !== 1'b1 || busy_s !== 1'b0) lows++;
        end
        check("midrst_quiet", lows, 32'd0);
        check("midrst_no_done", done_cnt[0] - dc0, 32'd0);
        push_packet(vt[3].payload, 9, vt[3].crc);
        pulse(0);
        recv_packet(11, "after_rst");
        wait_done(t_done, ok);
        check("after_rst_done", {31'd0, ok}, 32'd1);

        // Bit timing, N=1, payload 0xA5 (CRC 0x72).
        sel = 1;
        pay_b = 8'hA5;
        push_packet({64'd0, 8'hA5}, 1, 8'h72);
        repeat (2) @(negedge clk);
        pulse(1);
        stream_check(3, 0, "bit_timing");

        // GAP_BITS=2, N=1, payload 0x00: 360-clock frame.
        sel = 2;
        pay_c = 8'h00;
        push_packet(72'h0, 1, 8'h00);
        repeat (2) @(negedge clk);
        pulse(2);
        t_low = cyc;
        stream_check(3, 2, "gap");
        check("gap_frame_len", cyc - t_low, 32'd360);

        // Back-to-back with tx_start held high.
        sel = 1;
        repeat (2) @(negedge clk);
        pay_b = 8'h3C;
        push_packet({64'd0, 8'h3C}, 1, crc8_ref({64'd0, 8'h3C}, 1));
        start_b = 1'b1;
        @(negedge clk);
        for (int p = 0; p < 3; p++) begin
            stream_check(3, 0, $sformatf("b2b%0d", p));
            if (p < 2) begin
                pay_b = 8'h3C + 8'(p * 77 + 1);
                push_packet({64'd0, pay_b}, 1, crc8_ref({64'd0, pay_b}, 1));
            end else begin
                start_b = 1'b0;
            end
            @(negedge clk);
            check($sformatf("b2b%0d_idle_txd", p), {31'd0, txd_s}, 32'd1);
            check($sformatf("b2b%0d_idle_busy", p), {31'd0, busy_s}, 32'd0);
            @(negedge clk);
        end
        check("b2b_stopped", {31'd0, txd_s}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
